// File: rtl/mem_access_ctrl.sv
// M-stage data-bus controller: issues one valid/addr_ok/data_ok transaction per
// load/store, lane-aligns store data and strobes, and aligns/extends load data.
module mem_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          valid_m,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    size,
    input  logic          signed_ld,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          hold_m,
    output logic          dreq_valid,
    output logic [AW-1:0] dreq_addr,
    output logic [1:0]    dreq_size,
    output logic [3:0]    dreq_strobe,
    output logic [DW-1:0] dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [DW-1:0] dresp_data,
    output logic          stall_m,
    output logic [DW-1:0] rdata,
    output logic          misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          mem_op, access, issue, capture;
    logic [3:0]    in_strobe;
    logic [DW-1:0] in_data;

    logic [AW-1:0] req_addr_q;
    logic [1:0]    req_size_q;
    logic [3:0]    req_strobe_q;
    logic [DW-1:0] req_data_q;
    logic          req_load_q, req_signed_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    cur_lo, cur_size;
    logic          cur_load, cur_signed;
    logic [DW-1:0] shifted, ld_aligned;

    assign mem_op   = valid_m & (mem_read | mem_write);
    assign misalign = mem_op & (((size == 2'd1) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
    assign access   = mem_op & ~misalign;
    assign issue    = (state_q == IDLE) & access;

    assign in_data = wdata << {addr[1:0], 3'b000};

    // NOTE: every variable assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_strobe = 4'b0000;
        if (mem_write) begin
            case (size)
                2'd0:    in_strobe = 4'b0001 << addr[1:0];
                2'd1:    in_strobe = 4'b0011 << addr[1:0];
                default: in_strobe = 4'b1111;
            endcase
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; addr_ok is only looked at in IDLE and REQ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access) begin
                if (dresp_addr_ok & dresp_data_ok) state_d = DONE;
                else if (dresp_addr_ok)            state_d = WAIT;
                else                               state_d = REQ;
            end
            REQ: begin
                if (dresp_addr_ok & dresp_data_ok) state_d = DONE;
                else if (dresp_addr_ok)            state_d = WAIT;
            end
            WAIT: if (dresp_data_ok) state_d = DONE;
            DONE: if (!hold_m)       state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Request fields are captured as the FSM leaves IDLE and replayed from REQ on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_addr_q   <= '0;
            req_size_q   <= 2'd0;
            req_strobe_q <= 4'b0000;
            req_data_q   <= '0;
            req_load_q   <= 1'b0;
            req_signed_q <= 1'b0;
        end else if (issue) begin
            req_addr_q   <= addr;
            req_size_q   <= size;
            req_strobe_q <= in_strobe;
            req_data_q   <= in_data;
            req_load_q   <= mem_read & ~mem_write;
            req_signed_q <= signed_ld;
        end
    end

    // Data returning on the issue cycle has not reached the request registers yet.
    always_comb begin
        cur_lo     = req_addr_q[1:0];
        cur_size   = req_size_q;
        cur_load   = req_load_q;
        cur_signed = req_signed_q;
        if (state_q == IDLE) begin
            cur_lo     = addr[1:0];
            cur_size   = size;
            cur_load   = mem_read & ~mem_write;
            cur_signed = signed_ld;
        end
        shifted = dresp_data >> {cur_lo, 3'b000};
        case (cur_size)
            2'd0:    ld_aligned = {{24{cur_signed & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_aligned = {{16{cur_signed & shifted[15]}}, shifted[15:0]};
            default: ld_aligned = shifted;
        endcase
    end

    assign capture = dresp_data_ok & cur_load &
                     ((issue & dresp_addr_ok) | ((state_q == REQ) & dresp_addr_ok) | (state_q == WAIT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      rdata_q <= '0;
        else if (capture) rdata_q <= ld_aligned;
    end

    assign rdata = rdata_q;

    // Output logic.
    always_comb begin
        dreq_valid  = issue | (state_q == REQ);
        stall_m     = issue | (state_q == REQ) | (state_q == WAIT);
        dreq_addr   = req_addr_q;
        dreq_size   = req_size_q;
        dreq_strobe = req_strobe_q;
        dreq_data   = req_data_q;
        if (issue) begin
            dreq_addr   = addr;
            dreq_size   = size;
            dreq_strobe = in_strobe;
            dreq_data   = in_data;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions checked against an arithmetic model of the bus/alignment rules.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid_m = 1'b0, mem_read = 1'b0, mem_write = 1'b0, signed_ld = 1'b0, hold_m = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data, rdata, dresp_data = '0;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    logic        stall_m, misalign;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] prev_rdata = '0;

    mem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .valid_m(valid_m), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .hold_m(hold_m),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stall_m(stall_m), .rdata(rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [1:0] sz, input logic [1:0] a);
        logic [7:0] m;
        m = 8'(((1 << nbytes(sz)) - 1) << (nbytes(sz) == 4 ? 0 : int'(a)));
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
        longint s, v;
        int     nb;
        nb = nbytes(sz);
        s  = longint'(word >> (8 * int'(a)));
        v  = s % (longint'(1) << (8 * nb));
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // One complete access: addr_ok arrives on cycle a_cyc, data_ok on d_cyc (cycle 0 = issue).
    task automatic transact(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [31:0] wd, input int a_cyc,
                            input int d_cyc, input logic [31:0] word, input int hold);
        logic [31:0] exp_r;
        exp_r = (rd && !wr) ? ref_load(word, ad[1:0], sz, sg) : prev_rdata;
        for (int c = 0; c <= d_cyc; c++) begin
            @(negedge clk);
            valid_m = 1'b1; mem_read = rd; mem_write = wr; size = sz; signed_ld = sg;
            addr = ad; wdata = wd; hold_m = 1'($urandom_range(0, 1));
            dresp_addr_ok = (c == a_cyc);
            dresp_data_ok = (c == d_cyc);
            dresp_data    = (c == d_cyc) ? word : $urandom;
            #1;
            chk("stall_busy", {31'd0, stall_m}, 32'd1);
            chk("dreq_valid", {31'd0, dreq_valid}, {31'd0, c <= a_cyc});
            chk("no_misalign", {31'd0, misalign}, 32'd0);
            chk("rdata_old", rdata, prev_rdata);
            if (c <= a_cyc) begin
                chk("dreq_addr", dreq_addr, ad);
                chk("dreq_size", {30'd0, dreq_size}, {30'd0, sz});
                chk("dreq_strobe", {28'd0, dreq_strobe}, {28'd0, wr ? ref_strobe(sz, ad[1:0]) : 4'b0000});
                if (wr) chk("dreq_data", dreq_data, wd << (8 * int'(ad[1:0])));
            end
            @(posedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            hold_m        = (h < hold);
            dresp_addr_ok = 1'($urandom_range(0, 1));
            dresp_data_ok = 1'($urandom_range(0, 1));
            dresp_data    = $urandom;
            #1;
            chk("done_stall", {31'd0, stall_m}, 32'd0);
            chk("done_valid", {31'd0, dreq_valid}, 32'd0);
            chk("done_rdata", rdata, exp_r);
            @(posedge clk);
        end
        prev_rdata = exp_r;
    endtask

    task automatic misal(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] ad);
        @(negedge clk);
        valid_m = 1'b1; mem_read = rd; mem_write = wr; size = sz; addr = ad;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        #1;
        chk("misalign", {31'd0, misalign}, 32'd1);
        chk("mis_valid", {31'd0, dreq_valid}, 32'd0);
        chk("mis_stall", {31'd0, stall_m}, 32'd0);
        @(posedge clk);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        logic        op;
        int          a;

        #2;
        chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_m}, 32'd0);
        chk("rst_strobe", {28'd0, dreq_strobe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        transact(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
        transact(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 2, 5, 32'h80123456, 0);
        chk("sbyte", rdata, 32'hFFFFFF80);
        transact(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 2, 5, 32'h80123456, 0);
        chk("ubyte", rdata, 32'h00000080);
        transact(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 1, 2, 32'h13572468, 0);
        misal(1'b1, 1'b0, 2'd1, 32'h201);
        transact(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1, 3, 32'hCAFEF00D, 4);

        // Reset while waiting for data.
        @(negedge clk);
        valid_m = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; addr = 32'h300;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        #1;
        chk("wait_stall", {31'd0, stall_m}, 32'd1);
        chk("wait_valid", {31'd0, dreq_valid}, 32'd0);
        resetn = 1'b0; valid_m = 1'b0;
        #1;
        chk("arst_valid", {31'd0, dreq_valid}, 32'd0);
        chk("arst_stall", {31'd0, stall_m}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h12345678;
        #1;
        chk("stray_stall", {31'd0, stall_m}, 32'd0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("stray_rdata", rdata, 32'd0);
        prev_rdata = '0;
        transact(1'b1, 1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 0, 1, 32'h8001_7FFF, 0);

        for (int i = 0; i < 60; i++) begin
            op = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if (sz != 2'd0 && $urandom_range(0, 5) == 0) begin
                ad[1:0] = (sz == 2'd1) ? 2'b01 : 2'($urandom_range(1, 3));
                misal(op, ~op, sz, ad);
            end else begin
                if (sz == 2'd1) ad[0] = 1'b0;
                else if (sz[1]) ad[1:0] = 2'b00;
                a = $urandom_range(0, 3);
                transact(op, ~op, sz, 1'($urandom_range(0, 1)), ad, $urandom, a,
                         a + int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
